// File: rtl/uart_tx_if.sv
// Write-side handshake of the UART transmitter: a word is taken on the
// rising edge where i_valid and o_ready are both high.
interface uart_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default. Words enter a small FIFO over a
// valid/ready handshake and are shifted out LSB first on o_tx. A queued word
// is popped on the last cycle of the previous stop bit, so frames run
// back-to-back at full line rate.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued word
//   START | start bit (0) for BAUD_CLK cycles
//   DATA  | data bit shift[0], WIDTH bits, LSB first
//   STOP  | stop bit (1); pops the next word on its last cycle if one waits
module uart_tx #(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_tx_if.slave bus,
  output logic     o_tx,
  output logic     o_busy
);
  localparam int BAUD_CLK = CLK_HZ / BAUD;
  localparam int CNT_W    = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;
  localparam int BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int FCNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_idx_n;
  logic [WIDTH-1:0]  shift, shift_n;
  logic              tx_q, tx_n;
  logic              baud_tick;
  logic              pop, push;

  logic [WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count;
  logic              rdy_en;

  // rdy_en keeps o_ready low while reset is held; afterwards only the
  // registered count decides, so a pop in the same cycle never frees a slot.
  assign bus.o_ready = rdy_en && (count != FCNT_W'(FIFO_DEPTH));
  assign push        = bus.i_valid && bus.o_ready;
  assign baud_tick   = (baud_cnt == CNT_W'(BAUD_CLK - 1));
  assign o_tx        = tx_q;
  assign o_busy      = (state != ST_IDLE) || (count != '0);

  // FIFO storage, written on an accepted handshake
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo FIFO_DEPTH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state, bit timing and the registered serial output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  // Next-state, pop and next line level
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    unique case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_n = shift >> 1;
          if (bit_idx == BIT_W'(WIDTH - 1)) state_n = ST_STOP;
          else bit_idx_n = bit_idx + BIT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // the counter restarts on every bit boundary and every state change,
    // and rests at zero in IDLE so it can never run past BAUD_CLK-1
    if (state_n != state || baud_tick || state == ST_IDLE) baud_cnt_n = '0;
    else baud_cnt_n = baud_cnt + CNT_W'(1);

    unique case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  localparam int BCLK_S  = 416;   // 48 MHz / 115200, truncated
  localparam int FRAME_S = 4160;  // 10 bits * 416
  localparam int BCLK_F  = 8;     // 1 MHz / 125000

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_s, busy_s, tx_f, busy_f;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_if #(.WIDTH(8)) bus_s ();
  uart_tx_if #(.WIDTH(8)) bus_f ();

  uart_tx dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_s),
    .o_tx    (tx_s),
    .o_busy  (busy_s)
  );

  uart_tx #(.CLK_HZ(1000000), .BAUD(125000)) dut_f (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_f),
    .o_tx    (tx_f),
    .o_busy  (busy_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic line(input bit fast);
    return fast ? tx_f : tx_s;
  endfunction

  // Receive one frame by mid-bit sampling. t0 is the edge after which the
  // start bit began. On timeout all outputs are X.
  task automatic rx_frame(input bit fast, output logic [7:0] d, output logic st,
                          output logic sp, output int unsigned t0);
    int bclk;
    int k;
    bclk = fast ? BCLK_F : BCLK_S;
    d = 'x; st = 'x; sp = 'x; t0 = 0;
    k = 0;
    while (k < 30 * bclk) begin
      @(negedge clk);
      if (line(fast) === 1'b0) break;
      k++;
    end
    if (k >= 30 * bclk) return;
    t0 = cyc;
    repeat (bclk / 2) @(negedge clk);
    st = line(fast);
    for (int i = 0; i < 8; i++) begin
      repeat (bclk) @(negedge clk);
      d[i] = line(fast);
    end
    repeat (bclk) @(negedge clk);
    sp = line(fast);
  endtask

  task automatic test_reset();
    bus_s.i_valid = 1'b0; bus_s.i_data = '0;
    bus_f.i_valid = 1'b0; bus_f.i_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx_s); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_s); end
    n_cmp++; if (bus_s.o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus_s.o_ready); end
    n_cmp++; if (tx_f !== 1'b1) begin n_bad++; $display("FAIL reset_tx_fast: got %b want 1", tx_f); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_s.o_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", bus_s.o_ready); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL release_busy: got %b want 0", busy_s); end
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL release_tx: got %b want 1", tx_s); end
  endtask

  task automatic test_single();
    int unsigned a;
    logic [9:0] pat;
    pat = 10'b1010101010;  // sample i of 0x55 frame is pat[i]: 0,1,0,1,...
    bus_s.i_data = 8'h55; bus_s.i_valid = 1'b1;
    @(negedge clk);
    a = cyc;
    bus_s.i_valid = 1'b0;
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: got %b want 1", busy_s); end
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL single_tx_before_pop: got %b want 1", tx_s); end
    @(negedge clk);
    n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL single_start_latency: got %b want 0", tx_s); end
    for (int i = 0; i < 10; i++) begin
      while (cyc < a + 1 + 208 + 416 * i) @(negedge clk);
      n_cmp++;
      if (tx_s !== pat[i]) begin n_bad++; $display("FAIL single_bit%0d: got %b want %b", i, tx_s, pat[i]); end
    end
    while (cyc < a + FRAME_S) @(negedge clk);
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL single_busy_last: got %b want 1", busy_s); end
    @(negedge clk);
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", busy_s); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    logic [7:0] got [3];
    logic st [3];
    logic sp [3];
    int unsigned t [3];
    int unsigned a;
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA3;
    a = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          bus_s.i_data = exp[i]; bus_s.i_valid = 1'b1;
          @(negedge clk);
          if (i == 0) a = cyc;
        end
        bus_s.i_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) rx_frame(1'b0, got[j], st[j], sp[j], t[j]);
      end
    join
    n_cmp++; if (t[0] !== a + 1) begin n_bad++; $display("FAIL b2b_first_start: got edge %0d want %0d", t[0], a + 1); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], exp[i]); end
      n_cmp++; if (st[i] !== 1'b0 || sp[i] !== 1'b1) begin n_bad++; $display("FAIL b2b_framing%0d: got start %b stop %b want 0 1", i, st[i], sp[i]); end
      if (i > 0) begin
        n_cmp++;
        if (t[i] - t[i-1] !== FRAME_S) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d cycles want %0d", i, t[i] - t[i-1], FRAME_S); end
      end
    end
    while (cyc < t[0] + 3 * FRAME_S - 1) @(negedge clk);
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_last: got %b want 1", busy_s); end
    @(negedge clk);
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_fall: got %b want 0", busy_s); end
  endtask

  task automatic test_stream_full();
    logic [7:0] got [6];
    logic st [6];
    logic sp [6];
    int unsigned t [6];
    int unsigned a;
    int nacc;
    int k;
    a = 0; nacc = 0;
    fork
      begin
        bus_s.i_data = 8'h10; bus_s.i_valid = 1'b1;
        while (bus_s.o_ready === 1'b1 && nacc < 10) begin
          @(negedge clk);
          nacc++;
          if (nacc == 1) a = cyc;
          bus_s.i_data = bus_s.i_data + 8'h01;
        end
        n_cmp++; if (nacc !== 5) begin n_bad++; $display("FAIL stream_accepted: got %0d want 5", nacc); end
        bus_s.i_data = 8'hEE;
        repeat (50) @(negedge clk);
        n_cmp++; if (bus_s.o_ready !== 1'b0) begin n_bad++; $display("FAIL full_refuse: got ready %b want 0", bus_s.o_ready); end
        bus_s.i_valid = 1'b0;
        k = 0;
        while (bus_s.o_ready !== 1'b1 && k < 6000) begin @(negedge clk); k++; end
        n_cmp++; if (cyc !== a + FRAME_S + 1) begin n_bad++; $display("FAIL ready_return: got edge %0d want %0d", cyc, a + FRAME_S + 1); end
        bus_s.i_data = 8'h15; bus_s.i_valid = 1'b1;
        @(negedge clk);
        bus_s.i_valid = 1'b0;
        n_cmp++; if (bus_s.o_ready !== 1'b0) begin n_bad++; $display("FAIL ready_one_slot: got %b want 0", bus_s.o_ready); end
      end
      begin
        for (int j = 0; j < 6; j++) rx_frame(1'b0, got[j], st[j], sp[j], t[j]);
      end
    join
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (got[i] !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL stream_data%0d: got %h want %h", i, got[i], 8'(8'h10 + i)); end
      n_cmp++; if (st[i] !== 1'b0 || sp[i] !== 1'b1) begin n_bad++; $display("FAIL stream_framing%0d: got start %b stop %b want 0 1", i, st[i], sp[i]); end
      if (i > 0) begin
        n_cmp++;
        if (t[i] - t[i-1] !== FRAME_S) begin n_bad++; $display("FAIL stream_gap%0d: got %0d cycles want %0d", i, t[i] - t[i-1], FRAME_S); end
      end
    end
    while (cyc < t[5] + FRAME_S) @(negedge clk);
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL stream_no_ee_busy: got %b want 0", busy_s); end
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL stream_no_ee_tx: got %b want 1", tx_s); end
  endtask

  task automatic test_reset_midframe();
    int unsigned a;
    int lows;
    int busys;
    bus_s.i_data = 8'hC3; bus_s.i_valid = 1'b1;
    @(negedge clk);
    a = cyc;
    bus_s.i_data = 8'h01;
    @(negedge clk);
    bus_s.i_data = 8'h02;
    @(negedge clk);
    bus_s.i_valid = 1'b0;
    // middle of data bit 3: start bit begins at edge a+1, bit 3 is the 5th bit
    while (cyc < a + 1 + 4 * BCLK_S + 208) @(negedge clk);
    n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL midframe_bit3: got %b want 0", tx_s); end
    n_cmp++; if (busy_s !== 1'b1) begin n_bad++; $display("FAIL midframe_busy: got %b want 1", busy_s); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL abort_tx: got %b want 1", tx_s); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_s); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0; busys = 0;
    for (int k = 0; k < FRAME_S + BCLK_S; k++) begin
      @(negedge clk);
      if (tx_s !== 1'b1) lows++;
      if (busy_s !== 1'b0) busys++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL residual_tx: got %0d low cycles want 0", lows); end
    n_cmp++; if (busys !== 0) begin n_bad++; $display("FAIL residual_busy: got %0d busy cycles want 0", busys); end
    n_cmp++; if (bus_s.o_ready !== 1'b1) begin n_bad++; $display("FAIL after_abort_ready: got %b want 1", bus_s.o_ready); end
  endtask

  task automatic test_loopback();
    int wcount;
    int k;
    logic [7:0] d;
    logic st, sp;
    int unsigned t0;
    wcount = 0;
    fork
      begin
        for (int b = 0; b < 256; b++) begin
          k = 0;
          while (bus_f.o_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
          if (k >= 200) break;
          bus_f.i_data = 8'(b); bus_f.i_valid = 1'b1;
          @(negedge clk);
          bus_f.i_valid = 1'b0;
          wcount++;
        end
      end
      begin
        for (int j = 0; j < 256; j++) begin
          rx_frame(1'b1, d, st, sp, t0);
          n_cmp++; if (d !== 8'(j)) begin n_bad++; $display("FAIL loop_data%0d: got %h want %h", j, d, 8'(j)); end
          n_cmp++; if (st !== 1'b0 || sp !== 1'b1) begin n_bad++; $display("FAIL loop_frame_err%0d: got start %b stop %b want 0 1", j, st, sp); end
        end
      end
    join
    n_cmp++; if (wcount !== 256) begin n_bad++; $display("FAIL loop_written: got %0d want 256", wcount); end
    repeat (2 * BCLK_F) @(negedge clk);
    n_cmp++; if (busy_f !== 1'b0) begin n_bad++; $display("FAIL loop_busy_end: got %b want 0", busy_f); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stream_full();
    test_reset_midframe();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
